// File: rtl/i2s_rx_peripheral.sv
// i2s_rx_peripheral
//   Memory-mapped I2S microphone receiver. Generates SCK/WS for a stereo
//   I2S microphone, deserialises 16-bit left/right samples and queues
//   {left, right} frames in a FIFO that the CPU drains over the iomem bus.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   iomem_valid  bus request
//   iomem_ready  one-cycle acknowledge, the cycle after selection
//   iomem_wstrb  byte write strobes (0 = read)
//   iomem_addr   bus address; [31:16] selects the block, [3:2] the register
//   iomem_wdata  write data
//   iomem_rdata  read data, zero whenever iomem_ready is low
//   i2s_sck      I2S bit clock
//   i2s_ws       I2S word select (0 = left, 1 = right)
//   i2s_d0       I2S serial data from the microphone
//
// Register map (iomem_addr[3:2])
//   0 DATA    read pops {left, right}; returns 0 when empty
//   1 STATUS  [4:0] level, [8] empty, [9] full, [16] overflow (write 1 to clear)
//   2 CONTROL [0] enable, [1] flush (write-only, reads 0)
//   3         reads 0, writes ignored
module i2s_rx_peripheral #(
    parameter logic [15:0] ADDR  = 16'h5000,
    parameter int          DIV   = 4,
    parameter int          DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        i2s_sck,
    output logic        i2s_ws,
    input  logic        i2s_d0
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic          r_ready;
    logic [31:0]   r_rdata;
    logic          r_enable;
    logic          r_overflow;
    logic [DW-1:0] r_div;
    logic          r_sck;
    logic [5:0]    r_bc;
    logic [15:0]   r_left;
    logic [15:0]   r_right;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;

    logic          w_sel;
    logic          w_write;
    logic [1:0]    w_reg;
    logic          w_tick;
    logic          w_rise;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_flush;
    logic          w_ctrl_wr;
    logic          w_ovf_clr;
    logic          w_push_req;
    logic          w_push;
    logic          w_ovf_set;
    logic [31:0]   w_frame;
    logic [31:0]   w_status;
    logic [31:0]   w_rd_value;
    logic          w_unused;

    assign w_sel   = iomem_valid && !r_ready && (iomem_addr[31:16] == ADDR);
    assign w_write = |iomem_wstrb;
    assign w_reg   = iomem_addr[3:2];

    // One clk cycle per SCK half-period boundary; r_sck low means this
    // boundary is a rising edge (sample point), high means a falling edge.
    assign w_tick = r_enable && (r_div == DIV_LAST);
    assign w_rise = w_tick && !r_sck;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);

    assign w_pop     = w_sel && !w_write && (w_reg == 2'd0) && !w_empty;
    assign w_ctrl_wr = w_sel && w_write && (w_reg == 2'd2) && iomem_wstrb[0];
    assign w_flush   = w_ctrl_wr && iomem_wdata[1];
    assign w_ovf_clr = w_sel && w_write && (w_reg == 2'd1) && iomem_wstrb[2] && iomem_wdata[16];

    // The last right-channel bit is taken straight from the pin so the
    // frame is complete on the same edge that samples bc 48.
    assign w_push_req = w_rise && (r_bc == 6'd48);
    assign w_frame    = {r_left, r_right[14:0], i2s_d0};
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
    assign w_push     = w_push_req && !w_flush && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && !w_flush && w_full && !w_pop;

    always_comb begin
        w_status           = '0;
        w_status[LW-1:0]   = r_level;
        w_status[8]        = w_empty;
        w_status[9]        = w_full;
        w_status[16]       = r_overflow;
    end

    always_comb begin
        w_rd_value = '0;
        if (!w_write) begin
            case (w_reg)
                2'd0:    w_rd_value = w_empty ? 32'd0 : r_mem[r_rptr];
                2'd1:    w_rd_value = w_status;
                2'd2:    w_rd_value = {31'd0, r_enable};
                default: w_rd_value = '0;
            endcase
        end
    end

    // Frame storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_enable   <= 1'b0;
            r_overflow <= 1'b0;
            r_div      <= '0;
            r_sck      <= 1'b0;
            r_bc       <= '0;
            r_left     <= '0;
            r_right    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
        end else begin
            r_ready <= w_sel;
            r_rdata <= w_sel ? w_rd_value : 32'd0;

            if (w_ctrl_wr) begin
                r_enable <= iomem_wdata[0];
            end

            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_level <= r_level + LW'(1);
                end else if (!w_push && w_pop) begin
                    r_level <= r_level - LW'(1);
                end
            end

            // Disabling parks the bit engine at bc 0 so a re-enable starts
            // a fresh frame and any partial frame is simply never pushed.
            if (!r_enable) begin
                r_div <= '0;
                r_sck <= 1'b0;
                r_bc  <= '0;
            end else if (w_tick) begin
                r_div <= '0;
                r_sck <= !r_sck;
                if (r_sck) begin
                    r_bc <= r_bc + 6'd1;
                end
            end else begin
                r_div <= r_div + DW'(1);
            end

            if (w_rise && (r_bc >= 6'd1) && (r_bc <= 6'd16)) begin
                r_left <= {r_left[14:0], i2s_d0};
            end
            if (w_rise && (r_bc >= 6'd33) && (r_bc <= 6'd48)) begin
                r_right <= {r_right[14:0], i2s_d0};
            end
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign i2s_sck     = r_sck;
    assign i2s_ws      = r_bc[5];

    // Address/data bits outside the decoded fields are intentionally ignored.
    assign w_unused = &{1'b0, iomem_addr[15:4], iomem_addr[1:0],
                        iomem_wdata[31:17], iomem_wdata[15:2]};

endmodule

// File: tb/tb_i2s_rx_peripheral.sv
// tb_i2s_rx_peripheral
//   Directed bench for i2s_rx_peripheral. A behavioural microphone follows
//   SCK falling edges and shifts out per-frame left/right words
//   (base + frame index); bus reads are checked against hand-derived values.
//   With DIV = 4 the push of frame k lands on posedge en + 388 + 512*k,
//   where en is the posedge that registered the enable write.
module tb_i2s_rx_peripheral;

    localparam logic [31:0] A_DATA = 32'h5000_0000;
    localparam logic [31:0] A_STAT = 32'h5000_0004;
    localparam logic [31:0] A_CTRL = 32'h5000_0008;
    localparam logic [31:0] A_RSV  = 32'h5000_000C;
    localparam logic [31:0] A_FOREIGN = 32'h6000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'd0;
    logic [31:0] iomem_addr = 32'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic [31:0] iomem_rdata;
    logic        i2s_sck;
    logic        i2s_ws;
    logic        i2s_d0 = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // microphone model state
    logic        mic_clr = 1'b1;
    logic [15:0] base_l = 16'h0000;
    logic [15:0] base_r = 16'h0000;
    int          mic_bc = 0;
    int          mic_frame = 0;
    logic        sck_prev = 1'b0;
    logic        ws_prev = 1'b0;
    int          last_sck_rise = 0;
    int          last_ws_rise = 0;
    int          sck_period = 0;
    int          ws_period = 0;

    i2s_rx_peripheral #(
        .ADDR (16'h5000),
        .DIV  (4),
        .DEPTH(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .i2s_sck    (i2s_sck),
        .i2s_ws     (i2s_ws),
        .i2s_d0     (i2s_d0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic mic_bit(input int b, input logic [15:0] l, input logic [15:0] r);
        logic bit_v;
        bit_v = 1'b0;
        if (b >= 1 && b <= 16) bit_v = l[16 - b];
        else if (b >= 33 && b <= 48) bit_v = r[48 - b];
        return bit_v;
    endfunction

    // Microphone: advances its bit index on every SCK falling edge and
    // presents the next bit well before the following SCK rising edge.
    always @(negedge clk) begin
        logic [15:0] l_word;
        logic [15:0] r_word;
        if (!sck_prev && i2s_sck) begin
            sck_period = cyc - last_sck_rise;
            last_sck_rise = cyc;
        end
        if (!ws_prev && i2s_ws) begin
            ws_period = cyc - last_ws_rise;
            last_ws_rise = cyc;
        end
        if (mic_clr) begin
            mic_bc = 0;
            mic_frame = 0;
        end else if (sck_prev && !i2s_sck) begin
            if (mic_bc == 63) mic_frame = mic_frame + 1;
            mic_bc = (mic_bc + 1) % 64;
        end
        sck_prev = i2s_sck;
        ws_prev = i2s_ws;
        l_word = base_l + 16'(mic_frame);
        r_word = base_r + 16'(mic_frame);
        i2s_d0 = mic_bit(mic_bc, l_word, r_word);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the request is sampled on the next posedge
    // (returned as pc) and the response checked on the following negedge.
    // One idle cycle follows so every call starts with ready low.
    task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        output logic [31:0] rd, output logic rdy, output int pc);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wdata = wd;
        iomem_wstrb = ws;
        @(negedge clk);
        rdy = iomem_ready;
        rd  = iomem_rdata;
        pc  = cyc;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        $display("bus cyc=%0d addr=%08h wstrb=%h wdata=%08h ready=%0b rdata=%08h",
                 pc, a, ws, wd, rdy, rd);
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        rdy;
        int          pc;
        xfer(a, 32'd0, 4'd0, rd, rdy, pc);
        check({tag, "_ready"}, {31'd0, rdy}, 32'd1);
        check(tag, rd, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, output int pc);
        logic [31:0] rd;
        logic        rdy;
        xfer(a, wd, ws, rd, rdy, pc);
        check("write_ready", {31'd0, rdy}, 32'd1);
    endtask

    // Return at the negedge just before posedge t, so an xfer issued next
    // is sampled on posedge t.
    task automatic wait_to(input int t, input string tag);
        int guard;
        guard = 0;
        while (cyc < t - 1 && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        check(tag, 32'(cyc), 32'(t - 1));
    endtask

    initial begin
        int en;
        int pc;
        int nz;
        logic [31:0] rd;
        logic        rdy;

        // ---- reset state ----
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, iomem_ready}, 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_sck_ws", {30'd0, i2s_sck, i2s_ws}, 32'd0);
        rd_chk("rst_status", A_STAT, 32'h0000_0100);
        rd_chk("rst_control", A_CTRL, 32'h0000_0000);
        rd_chk("reserved_reg", A_RSV, 32'h0000_0000);
        rd_chk("empty_data", A_DATA, 32'h0000_0000);

        nz = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i2s_sck !== 1'b0 || i2s_ws !== 1'b0) nz++;
        end
        check("idle_sck_ws_1000", 32'(nz), 32'd0);

        // ---- single frame A5C3 / 1234 ----
        base_l = 16'hA5C3;
        base_r = 16'h1234;
        wr(A_CTRL, 32'h1, 4'h1, en);
        mic_clr = 1'b0;
        wait_to(en + 450, "sync_f0");
        check("sck_period", 32'(sck_period), 32'd8);
        rd_chk("frame0_data", A_DATA, 32'hA5C3_1234);
        rd_chk("frame0_status", A_STAT, 32'h0000_0100);

        // disable + flush mid-frame (ws is high here, bc ~57)
        mic_clr = 1'b1;
        wr(A_CTRL, 32'h2, 4'h1, pc);
        repeat (3) @(negedge clk);
        check("dis_sck_ws", {30'd0, i2s_sck, i2s_ws}, 32'd0);
        rd_chk("dis_status", A_STAT, 32'h0000_0100);
        rd_chk("dis_control", A_CTRL, 32'h0000_0000);

        // ---- 17 frames with no reads: fill and overflow ----
        base_l = 16'h1100;
        base_r = 16'h2200;
        wr(A_CTRL, 32'h1, 4'h1, en);
        mic_clr = 1'b0;
        wait_to(en + 8700, "sync_full");
        check("ws_period", 32'(ws_period), 32'd512);
        check("sck_period_2", 32'(sck_period), 32'd8);
        rd_chk("full_status", A_STAT, 32'h0001_0210);
        for (int k = 0; k < 16; k++) begin
            rd_chk($sformatf("drain%0d", k), A_DATA,
                   {16'h1100 + 16'(k), 16'h2200 + 16'(k)});
        end
        rd_chk("drain16_empty", A_DATA, 32'h0000_0000);

        // ---- overflow clear, flush at level 5 ----
        wr(A_STAT, 32'h0001_0000, 4'h4, pc);
        rd_chk("ovf_cleared", A_STAT, 32'h0000_0100);
        wait_to(en + 11300, "sync_lvl5");
        rd_chk("level5", A_STAT, 32'h0000_0005);
        wr(A_CTRL, 32'h3, 4'h1, pc);
        rd_chk("flush_status", A_STAT, 32'h0000_0100);
        rd_chk("flush_enable", A_CTRL, 32'h0000_0001);

        // ---- pop coinciding with push at level 3 ----
        wait_to(en + 12800, "sync_lvl3");
        rd_chk("level3", A_STAT, 32'h0000_0003);
        wait_to(en + 13188, "sync_coincide");
        xfer(A_DATA, 32'd0, 4'd0, rd, rdy, pc);
        check("coincide_cycle", 32'(pc), 32'(en + 13188));
        check("coincide_data", rd, {16'h1100 + 16'd22, 16'h2200 + 16'd22});
        rd_chk("coincide_level", A_STAT, 32'h0000_0003);
        for (int k = 23; k < 26; k++) begin
            rd_chk($sformatf("order%0d", k), A_DATA,
                   {16'h1100 + 16'(k), 16'h2200 + 16'(k)});
        end
        rd_chk("after_order", A_STAT, 32'h0000_0100);

        // ---- foreign address: no ready, rdata stays 0 ----
        iomem_valid = 1'b1;
        iomem_addr  = A_FOREIGN | 32'h4;
        iomem_wstrb = 4'd0;
        nz = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (iomem_ready !== 1'b0 || iomem_rdata !== 32'd0) nz++;
        end
        iomem_valid = 1'b0;
        $display("bus foreign addr=%08h ready/rdata nonzero cycles=%0d", A_FOREIGN | 32'h4, nz);
        check("foreign_addr", 32'(nz), 32'd0);
        @(negedge clk);

        // ---- reset mid-frame at bc 20 with level 4 ----
        wait_to(en + 15300, "sync_lvl4");
        rd_chk("level4", A_STAT, 32'h0000_0004);
        wait_to(en + 15520, "sync_bc20");
        mic_clr = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {iomem_rdata[29:0], iomem_ready, i2s_sck},
              32'd0);
        check("midrst_ws", {31'd0, i2s_ws}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, iomem_ready}, 32'd0);
        rd_chk("post_rst_status", A_STAT, 32'h0000_0100);
        rd_chk("post_rst_control", A_CTRL, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_peripheral.md
I2S_RX_PERIPHERAL -- requirements
Module: i2s_rx_peripheral

Interface
REQ-001 Parameter ADDR, default 16'h5000, iomem_addr[31:16] match value that selects this block.
REQ-002 Parameter DIV, default 4, clk cycles per SCK half-period (DIV >= 2).
REQ-003 Parameter DEPTH, default 16, FIFO depth in frames (power of 2).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 iomem_valid  input  1  bus request.
REQ-007 iomem_ready  output  1  one-cycle bus acknowledge.
REQ-008 iomem_wstrb  input  4  byte write strobes; 0 = read.
REQ-009 iomem_addr  input  32  bus address.
REQ-010 iomem_wdata  input  32  write data.
REQ-011 iomem_rdata  output  32  read data.
REQ-012 i2s_sck  output  1  I2S bit clock to microphone.
REQ-013 i2s_ws  output  1  I2S word select; 0 = left, 1 = right.
REQ-014 i2s_d0  input  1  I2S serial data from microphone.

Function
REQ-015 Selection: sel = iomem_valid && !iomem_ready && iomem_addr[31:16]==ADDR.
REQ-016 iomem_ready SHALL pulse high exactly one cycle, the cycle after sel; never two consecutive cycles.
REQ-017 iomem_rdata SHALL be 0 whenever iomem_ready is 0, so that it can be OR-combined with other slaves.
REQ-018 Register map (iomem_addr[3:2]): 0 DATA (RO), 1 STATUS, 2 CONTROL; 3 reads 0, writes ignored.
REQ-019 DATA read: FIFO not empty -> return head frame {left[15:0], right[15:0]} and pop; empty -> return 0, no pop.
REQ-020 STATUS read: [4:0] level (0..DEPTH), [8] empty, [9] full, [16] overflow sticky; other bits 0.
REQ-021 STATUS write with wstrb[2] && wdata[16] SHALL clear overflow.
REQ-022 CONTROL: bit0 enable (R/W); writing 1 to bit1 flushes the FIFO (level 0) and the bit reads as 0.
REQ-023 Enable = 0: i2s_sck and i2s_ws held 0, divider and bit counter held 0, no pushes; FIFO contents retained.
REQ-024 Enable = 1: i2s_sck toggles every DIV clk cycles, starting high after the first DIV cycles.
REQ-025 6-bit bit counter bc increments on each SCK falling edge, wraps 63->0; i2s_ws = bc[5].
REQ-026 Data sampled on the clk cycle of each SCK rising edge.
REQ-027 Left sample = bits at bc 1..16, MSB first; right sample = bits at bc 33..48, MSB first (one-bit I2S delay).
REQ-028 Push of {left,right} SHALL occur on the SCK rising edge that samples bc 48.
REQ-029 Push while full: frame dropped, FIFO unchanged, overflow set.
REQ-030 Push and pop in the same cycle: both occur; level unchanged; when empty, the pop returns 0 and the push still occurs.
REQ-031 Flush in the same cycle as a push: flush wins; level 0.
REQ-032 Clearing enable mid-frame discards the partial frame; re-enable restarts at bc 0.

Reset
REQ-033 On reset: iomem_ready 0, iomem_rdata 0, i2s_sck 0, i2s_ws 0, enable 0, overflow 0, FIFO level 0, bc 0, divider 0.
REQ-034 Reset asserted mid-transaction or mid-frame SHALL abort it; no ready pulse in the cycle after reset deasserts unless sel is asserted in that cycle.

Verification
REQ-035 Reset, read STATUS -> rdata 0x00000100; i2s_sck/i2s_ws stay 0 for 1000 cycles.
REQ-036 Enable, DIV=4, model drives left 0xA5C3 / right 0x1234 -> SCK period 8 clk, frame 512 clk; DATA read returns 0xA5C31234, then STATUS level 0.
REQ-037 Enable, no reads for 17 frames -> STATUS = 0x00010210 (level 16, full, overflow); 16 DATA reads return first 16 frames in order; 17th returns 0.
REQ-038 Write STATUS 0x00010000 -> overflow 0; write CONTROL 0x3 with FIFO level 5 -> level 0, enable stays 1.
REQ-039 Pop coinciding with push at level 3 -> level stays 3, data order preserved; read of ADDR 0x6000xxxx -> no ready, rdata stays 0.
REQ-040 Assert reset at bc 20 with level 4 -> all outputs at reset values next cycle; STATUS reads 0x00000100.
